// File: rtl/multiplicacion_entera_if.sv
// Start/done handshake bundle for the shift-and-add multiplier P = Q*B + R.
interface multiplicacion_entera_if #(
    parameter int unsigned N = 8
);
    logic           start;
    logic [N-1:0]   Q;
    logic [N-1:0]   B;
    logic [N-1:0]   R;
    logic [2*N-1:0] P;
    logic           done;
    logic           busy;

    modport master (output start, Q, B, R, input P, done, busy);
    modport slave  (input start, Q, B, R, output P, done, busy);
endinterface

// File: rtl/multiplicacion_entera.sv
// Sequential unsigned multiplier with addend, one multiplier bit per clock.
// Rebuilds a dividend from quotient, divisor and remainder: P = Q*B + R.
module multiplicacion_entera #(
    parameter int unsigned N = 8
) (
    input logic                     clk,
    input logic                     rst,
    multiplicacion_entera_if.slave  bus
);
    localparam int unsigned PW = 2 * N;
    localparam int unsigned CW = $clog2(N + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [PW-1:0]   acc_q, acc_d;
    logic [PW-1:0]   mcand_q, mcand_d;
    logic [N-1:0]    mplier_q, mplier_d;
    logic [CW-1:0]   count_q, count_d;
    logic [PW-1:0]   p_q, p_d;
    logic            done_q, done_d;

    // State and datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            count_q  <= '0;
            p_q      <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            count_q  <= count_d;
            p_q      <= p_d;
            done_q   <= done_d;
        end
    end

    // Next-state and datapath update; CALC always runs N cycles regardless of data
    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        count_d  = count_q;
        p_d      = p_q;
        done_d   = done_q;

        case (state_q)
            IDLE: begin
                done_d = 1'b0;
                if (bus.start) begin
                    acc_d    = PW'(bus.R);
                    mcand_d  = PW'(bus.B);
                    mplier_d = bus.Q;
                    count_d  = CW'(N);
                    state_d  = CALC;
                end
            end
            CALC: begin
                if (mplier_q[0]) begin
                    acc_d = acc_q + mcand_q;
                end
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                count_d  = count_q - CW'(1);
                if (count_q == CW'(1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                p_d    = acc_q;
                done_d = 1'b1;
                // Park here while start stays high so a held request yields one result
                if (!bus.start) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.P    = p_q;
    assign bus.done = done_q;
    assign bus.busy = (state_q != IDLE);
endmodule

// File: tb/tb_multiplicacion_entera.sv
// Directed and random checks of multiplicacion_entera at N = 4, 8 and 16.
`timescale 1ns/1ps
module tb_multiplicacion_entera;
    typedef logic [63:0] u64;

    logic clk;
    logic rst;
    int   pass_cnt;
    int   total_cnt;

    multiplicacion_entera_if #(.N(8))  bus8  ();
    multiplicacion_entera_if #(.N(4))  bus4  ();
    multiplicacion_entera_if #(.N(16)) bus16 ();

    multiplicacion_entera #(.N(8))  dut8  (.clk(clk), .rst(rst), .bus(bus8));
    multiplicacion_entera #(.N(4))  dut4  (.clk(clk), .rst(rst), .bus(bus4));
    multiplicacion_entera #(.N(16)) dut16 (.clk(clk), .rst(rst), .bus(bus16));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One full request: hold start until done, then drop it and wait for IDLE with done low
`define DEF_RUN(NAME, IFC, W) \
    task automatic NAME(input u64 q, input u64 b, input u64 r, output u64 p, output int lat, output bit busy_ok); \
        busy_ok = 1'b1; \
        lat = 0; \
        IFC.Q = q[W-1:0]; \
        IFC.B = b[W-1:0]; \
        IFC.R = r[W-1:0]; \
        IFC.start = 1'b1; \
        do begin \
            @(negedge clk); \
            lat++; \
            if (!IFC.done && !IFC.busy) busy_ok = 1'b0; \
        end while (!IFC.done && lat < 200); \
        p = 64'(IFC.P); \
        IFC.start = 1'b0; \
        for (int k = 0; k < 4 && (IFC.busy || IFC.done); k++) @(negedge clk); \
    endtask

    `DEF_RUN(run8, bus8, 8)
    `DEF_RUN(run4, bus4, 4)
    `DEF_RUN(run16, bus16, 16)

    // Random dividend A and nonzero divisor, A bounded so the quotient fits W bits
`define DEF_RANDOM(NAME, RUN, W) \
    task automatic NAME; \
        u64 a, b, p; \
        int lat; \
        bit bok; \
        int errs; \
        errs = 0; \
        for (int i = 0; i < 1000; i++) begin \
            b = u64'($urandom_range(1, (1 << W) - 1)); \
            a = {$urandom(), $urandom()} % (b << W); \
            RUN(a / b, b, a % b, p, lat, bok); \
            total_cnt++; \
            if (p !== a || lat !== W + 2) begin \
                errs++; \
                if (errs <= 5) $display("FAIL random_n%0d: A=%0d B=%0d got P=%0d lat=%0d, want P=%0d lat=%0d", W, a, b, p, lat, a, W + 2); \
            end else begin \
                pass_cnt++; \
            end \
        end \
    endtask

    `DEF_RANDOM(test_random_n8, run8, 8)
    `DEF_RANDOM(test_random_n4, run4, 4)
    `DEF_RANDOM(test_random_n16, run16, 16)

    task automatic test_reset;
        rst = 1'b1;
        bus8.start = 1'b0;  bus8.Q = '0;  bus8.B = '0;  bus8.R = '0;
        bus4.start = 1'b0;  bus4.Q = '0;  bus4.B = '0;  bus4.R = '0;
        bus16.start = 1'b0; bus16.Q = '0; bus16.B = '0; bus16.R = '0;
        repeat (3) @(negedge clk);
        total_cnt++;
        if (bus8.P !== 16'h0000) $display("FAIL reset_p: got %h want 0000", bus8.P); else pass_cnt++;
        total_cnt++;
        if (bus8.done !== 1'b0) $display("FAIL reset_done: got %b want 0", bus8.done); else pass_cnt++;
        total_cnt++;
        if (bus8.busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", bus8.busy); else pass_cnt++;
        total_cnt++;
        if (bus16.P !== 32'h0 || bus4.P !== 8'h0) $display("FAIL reset_p_other: got %h/%h want 0/0", bus16.P, bus4.P); else pass_cnt++;
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic;
        u64 p;
        int lat;
        bit bok;
        run8(13, 11, 5, p, lat, bok);
        total_cnt++;
        if (p !== 64'd148) $display("FAIL basic_p: got %0d want 148", p); else pass_cnt++;
        total_cnt++;
        if (lat !== 10) $display("FAIL basic_latency: got %0d want 10", lat); else pass_cnt++;
        total_cnt++;
        if (bok !== 1'b1) $display("FAIL basic_busy: got %b want 1", bok); else pass_cnt++;
        total_cnt++;
        if (bus8.done !== 1'b0 || bus8.busy !== 1'b0) $display("FAIL basic_idle: got done=%b busy=%b want 0/0", bus8.done, bus8.busy); else pass_cnt++;
    endtask

    task automatic test_edges;
        u64 p;
        int lat;
        bit bok;
        run8(255, 255, 254, p, lat, bok);
        total_cnt++;
        if (p !== 64'hFEFF) $display("FAIL edge_max: got %h want feff", p); else pass_cnt++;
        run8(0, 200, 7, p, lat, bok);
        total_cnt++;
        if (p !== 64'd7) $display("FAIL edge_q0: got %0d want 7", p); else pass_cnt++;
        run8(9, 0, 3, p, lat, bok);
        total_cnt++;
        if (p !== 64'd3) $display("FAIL edge_b0: got %0d want 3", p); else pass_cnt++;
        run8(1, 77, 10, p, lat, bok);
        total_cnt++;
        if (p !== 64'd87) $display("FAIL edge_q1: got %0d want 87", p); else pass_cnt++;
        total_cnt++;
        if (lat !== 10) $display("FAIL edge_latency: got %0d want 10", lat); else pass_cnt++;
    endtask

    task automatic test_start_held;
        int  rises;
        logic prev;
        rises = 0;
        bus8.Q = 8'd3; bus8.B = 8'd4; bus8.R = 8'd1;
        bus8.start = 1'b1;
        prev = bus8.done;
        repeat (40) begin
            @(negedge clk);
            if (bus8.done && !prev) rises++;
            prev = bus8.done;
        end
        total_cnt++;
        if (rises !== 1) $display("FAIL held_results: got %0d want 1", rises); else pass_cnt++;
        total_cnt++;
        if (bus8.P !== 16'd13) $display("FAIL held_p: got %0d want 13", bus8.P); else pass_cnt++;
        total_cnt++;
        if (bus8.done !== 1'b1) $display("FAIL held_done: got %b want 1", bus8.done); else pass_cnt++;
        bus8.start = 1'b0;
        @(negedge clk);
        total_cnt++;
        if (bus8.done !== 1'b1) $display("FAIL held_done_edge1: got %b want 1", bus8.done); else pass_cnt++;
        @(negedge clk);
        total_cnt++;
        if (bus8.done !== 1'b0 || bus8.busy !== 1'b0) $display("FAIL held_release: got done=%b busy=%b want 0/0", bus8.done, bus8.busy); else pass_cnt++;
    endtask

    task automatic test_capture;
        int lat;
        bus8.Q = 8'd6; bus8.B = 8'd7; bus8.R = 8'd2;
        bus8.start = 1'b1;
        @(negedge clk);
        bus8.Q = 8'd200; bus8.B = 8'd201; bus8.R = 8'd202;
        bus8.start = 1'b0;
        @(negedge clk);
        bus8.start = 1'b1;
        @(negedge clk);
        bus8.start = 1'b0;
        @(negedge clk);
        bus8.start = 1'b1;
        lat = 0;
        while (!bus8.done && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        total_cnt++;
        if (bus8.P !== 16'd44 || bus8.done !== 1'b1) $display("FAIL capture_p: got P=%0d done=%b want 44/1", bus8.P, bus8.done); else pass_cnt++;
        bus8.start = 1'b0;
        repeat (2) @(negedge clk);
        total_cnt++;
        if (bus8.P !== 16'd44 || bus8.done !== 1'b0) $display("FAIL hold_idle: got P=%0d done=%b want 44/0", bus8.P, bus8.done); else pass_cnt++;
        bus8.Q = 8'd2; bus8.B = 8'd3; bus8.R = 8'd0;
        bus8.start = 1'b1;
        repeat (3) @(negedge clk);
        total_cnt++;
        if (bus8.P !== 16'd44 || bus8.busy !== 1'b1) $display("FAIL hold_calc: got P=%0d busy=%b want 44/1", bus8.P, bus8.busy); else pass_cnt++;
        lat = 0;
        while (!bus8.done && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        total_cnt++;
        if (bus8.P !== 16'd6) $display("FAIL capture_next: got %0d want 6", bus8.P); else pass_cnt++;
        bus8.start = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset_mid;
        u64 p;
        int lat;
        bit bok;
        bus8.Q = 8'd200; bus8.B = 8'd100; bus8.R = 8'd50;
        bus8.start = 1'b1;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        #1;
        total_cnt++;
        if (bus8.P !== 16'd0) $display("FAIL midrst_p: got %0d want 0", bus8.P); else pass_cnt++;
        total_cnt++;
        if (bus8.done !== 1'b0 || bus8.busy !== 1'b0) $display("FAIL midrst_flags: got done=%b busy=%b want 0/0", bus8.done, bus8.busy); else pass_cnt++;
        bus8.start = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        run8(5, 6, 7, p, lat, bok);
        total_cnt++;
        if (p !== 64'd37 || lat !== 10) $display("FAIL midrst_after: got P=%0d lat=%0d want 37/10", p, lat); else pass_cnt++;
    endtask

    initial begin
        pass_cnt  = 0;
        total_cnt = 0;
        test_reset();
        test_basic();
        test_edges();
        test_start_held();
        test_capture();
        test_reset_mid();
        test_random_n8();
        test_random_n4();
        test_random_n16();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
